// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state encoding and grant constants for the irrigation scheduler
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN_GOT = 2'b01,
    ST_RUN_ASP = 2'b10,
    ST_SETTLE  = 2'b11
  } state_t;

  localparam logic GRANT_GOT = 1'b0;
  localparam logic GRANT_ASP = 1'b1;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enable_divider.sv
// rtl/enable_divider.sv - registered one-cycle enable pulse every DIV clock cycles
module enable_divider import irrigation_pkg::*; #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic pulse
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= (cnt == LAST);
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - arbitrates one water supply between drip and sprinkler valves
module irrigation_scheduler import irrigation_pkg::*; #(
  parameter int TICK_DIV = 4194304,
  parameter int SEL_HALF = 65536,
  parameter int GOT_MAX  = 16,
  parameter int ASP_MAX  = 8,
  parameter int SETTLE   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_got,
  input  logic       req_asp,
  input  logic       water_ok,
  output logic       valve_got,
  output logic       valve_asp,
  output logic       sel,
  output logic       tick,
  output logic [1:0] state_code,
  output logic       err_water
);

  localparam int RMAX_A = (GOT_MAX > ASP_MAX) ? GOT_MAX : ASP_MAX;
  localparam int RMAX   = (RMAX_A > SETTLE) ? RMAX_A : SETTLE;
  localparam int RW     = cnt_width(RMAX);
  localparam logic [RW-1:0] GOT_LAST    = RW'(GOT_MAX - 1);
  localparam logic [RW-1:0] ASP_LAST    = RW'(ASP_MAX - 1);
  localparam logic [RW-1:0] SETTLE_LAST = RW'(SETTLE - 1);

  state_t        state;
  logic [RW-1:0] rcnt;
  logic          last_grant;
  logic          sel_en;

  enable_divider #(.DIV(TICK_DIV)) u_tick_div (
    .clock (clock),
    .reset (reset),
    .pulse (tick)
  );

  enable_divider #(.DIV(SEL_HALF)) u_sel_div (
    .clock (clock),
    .reset (reset),
    .pulse (sel_en)
  );

  always_ff @(posedge clock) begin
    if (reset) sel <= 1'b0;
    else       sel <= sel ^ sel_en;
  end

  assign state_code = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      rcnt       <= '0;
      last_grant <= GRANT_ASP;
      valve_got  <= 1'b0;
      valve_asp  <= 1'b0;
      err_water  <= 1'b0;
    end else begin
      err_water <= water_ok ? 1'b0 : (err_water | req_got | req_asp);
      case (state)
        ST_IDLE: begin
          // Old err_water blocks the grant on the edge that clears it.
          if (water_ok && !err_water && (req_got || req_asp)) begin
            rcnt <= '0;
            if (req_got && (!req_asp || last_grant == GRANT_ASP)) begin
              state      <= ST_RUN_GOT;
              valve_got  <= 1'b1;
              last_grant <= GRANT_GOT;
            end else begin
              state      <= ST_RUN_ASP;
              valve_asp  <= 1'b1;
              last_grant <= GRANT_ASP;
            end
          end
        end
        ST_RUN_GOT: begin
          if (!water_ok) begin
            state     <= ST_IDLE;
            valve_got <= 1'b0;
          end else if (!req_got || (tick && rcnt == GOT_LAST)) begin
            state     <= ST_SETTLE;
            valve_got <= 1'b0;
            rcnt      <= '0;
          end else begin
            rcnt <= rcnt + RW'(tick);
          end
        end
        ST_RUN_ASP: begin
          if (!water_ok) begin
            state     <= ST_IDLE;
            valve_asp <= 1'b0;
          end else if (!req_asp || (tick && rcnt == ASP_LAST)) begin
            state     <= ST_SETTLE;
            valve_asp <= 1'b0;
            rcnt      <= '0;
          end else begin
            rcnt <= rcnt + RW'(tick);
          end
        end
        ST_SETTLE: begin
          if (tick && rcnt == SETTLE_LAST) state <= ST_IDLE;
          else                             rcnt  <= rcnt + RW'(tick);
        end
        default: begin
          state     <= ST_IDLE;
          valve_got <= 1'b0;
          valve_asp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - scoreboard bench for irrigation_scheduler
module tb_irrigation_scheduler;

  localparam int TDIV  = 4;
  localparam int SHALF = 2;
  localparam int GMAX  = 3;
  localparam int AMAX  = 2;
  localparam int SET   = 1;

  localparam int M_IDLE = 0;
  localparam int M_GOT  = 1;
  localparam int M_ASP  = 2;
  localparam int M_SETL = 3;

  logic       clock = 1'b0;
  logic       reset, req_got, req_asp, water_ok;
  logic       valve_got, valve_asp, sel, tick, err_water;
  logic [1:0] state_code;

  irrigation_scheduler #(
    .TICK_DIV (TDIV),
    .SEL_HALF (SHALF),
    .GOT_MAX  (GMAX),
    .ASP_MAX  (AMAX),
    .SETTLE   (SET)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_got    (req_got),
    .req_asp    (req_asp),
    .water_ok   (water_ok),
    .valve_got  (valve_got),
    .valve_asp  (valve_asp),
    .sel        (sel),
    .tick       (tick),
    .state_code (state_code),
    .err_water  (err_water)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       vg;
    logic       va;
    logic       sel;
    logic       tick;
    logic       err;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_mode, m_cnt, m_last, m_k;
  logic m_err;

  function automatic logic tick_at(input int k);
    return (k >= TDIV) && (k % TDIV == 0);
  endfunction

  function automatic logic sel_at(input int k);
    return (k == 0) ? 1'b0 : (((k - 1) / SHALF) % 2 == 1);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: k counts edges since reset release; tick/sel follow from it directly.
  task automatic model(input logic r, input logic rg, input logic ra, input logic wo,
                       output exp_t e);
    logic t;
    logic want;
    int   lim;
    if (r) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_last = M_ASP;
      m_err  = 1'b0;
      m_k    = 0;
    end else begin
      t = tick_at(m_k);
      m_k++;
      case (m_mode)
        M_IDLE: begin
          if (wo && !m_err) begin
            if (rg && ra)  m_mode = (m_last == M_ASP) ? M_GOT : M_ASP;
            else if (rg)   m_mode = M_GOT;
            else if (ra)   m_mode = M_ASP;
            if (m_mode != M_IDLE) begin
              m_last = m_mode;
              m_cnt  = 0;
            end
          end
        end
        M_GOT, M_ASP: begin
          want = (m_mode == M_GOT) ? rg : ra;
          lim  = (m_mode == M_GOT) ? GMAX : AMAX;
          if (!wo) m_mode = M_IDLE;
          else if (!want || (t && m_cnt == lim - 1)) begin
            m_mode = M_SETL;
            m_cnt  = 0;
          end else m_cnt += int'(t);
        end
        default: begin
          if (t && m_cnt == SET - 1) m_mode = M_IDLE;
          else                       m_cnt += int'(t);
        end
      endcase
      m_err = wo ? 1'b0 : (m_err | rg | ra);
    end
    e.vg   = (m_mode == M_GOT);
    e.va   = (m_mode == M_ASP);
    e.sel  = r ? 1'b0 : sel_at(m_k);
    e.tick = r ? 1'b0 : tick_at(m_k);
    e.err  = m_err;
    e.code = 2'(m_mode);
  endtask

  task automatic step(input logic r, input logic rg, input logic ra, input logic wo);
    exp_t e;
    reset    = r;
    req_got  = rg;
    req_asp  = ra;
    water_ok = wo;
    model(r, rg, ra, wo, e);
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valve_got",  {1'b0, valve_got}, {1'b0, e.vg});
        check("valve_asp",  {1'b0, valve_asp}, {1'b0, e.va});
        check("state_code", state_code,        e.code);
        check("tick",       {1'b0, tick},      {1'b0, e.tick});
        check("sel",        {1'b0, sel},       {1'b0, e.sel});
        check("err_water",  {1'b0, err_water}, {1'b0, e.err});
        check("no_overlap", {1'b0, valve_got & valve_asp}, 2'b00);
      end
    end
  end

  initial begin
    logic rg, ra, wo, r;
    reset = 1'b1; req_got = 1'b0; req_asp = 1'b0; water_ok = 1'b0;

    repeat (3)  step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1, 1'b1, 1'b1);

    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1);

    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3)  step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);

    rg = 1'b0; ra = 1'b0; wo = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0)  rg = ~rg;
      if ($urandom_range(7) == 0)  ra = ~ra;
      if ($urandom_range(11) == 0) wo = ~wo;
      r = ($urandom_range(199) == 0);
      step(r, rg, ra, wo);
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
